cla_addsub_pipe: RTL and testbench
==================================

# cla_addsub_pipe

Pipelined, parametrised carry-lookahead adder/subtractor for the ALU datapath; next generation of the single-cycle CLA adder. Splits an N-bit add/subtract into N/BLK carry-lookahead slices, one pipeline stage per slice. Accepts one operation per cycle under a valid/ready handshake and returns sum, signed overflow, carry-out and zero flag. Sits between the operand-select stage and the ALU result mux.

## Interface
- N, 32, operand/result width; must be a multiple of BLK (elaboration error otherwise)
- BLK, 8, bits resolved per pipeline stage; must be a multiple of 4; L = N/BLK = latency in cycles
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept this cycle
- a  in  N  operand A (two's complement or unsigned)
- b  in  N  operand B
- sub  in  1  0 = A+B, 1 = A−B
- cin  in  1  carry-in when sub=0; borrow-in when sub=1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  N  result
- ovf  out  1  signed overflow
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- zero  out  1  s == 0

## Operation
- Effective operation: s = a + (sub ? ~b : b) + (sub ? ~cin : cin), mod 2^N.
- ovf = carry into MSB XOR carry out of MSB; cout = carry out of MSB.
- Stage k (k = 0..L−1) computes bits [k*BLK +: BLK] from registered operand slice and registered carry from stage k−1; stage 0 uses the effective carry-in.
- Operand slices for later stages travel through skew registers; completed sum slices travel through deskew registers, so all N result bits appear together.
- Each stage holds a valid bit; stage L−1 drives out_valid, s, ovf, cout, zero.
- Global advance enable: adv = !out_valid || out_ready. When adv=1 all stages shift one position; when adv=0 every stage register (data and valid) holds.
- in_ready = adv (combinational). Transfer on input when in_valid && in_ready; otherwise a bubble (valid=0) enters stage 0.
- Bubbles are not collapsed; ordering is strictly FIFO.
- zero computed from the full assembled sum in the last stage, registered with it.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream): all valid bits 0, out_valid=0, s=0, ovf=0, cout=0, zero=0; in_ready=1 on first cycle after reset.
- Reset mid-operation: all in-flight transactions discarded, no partial result emitted.
- Latency: operation accepted at edge t is presented with out_valid=1 after edge t+L when no stall occurs (L=4 for defaults).
- Throughput: one operation per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 → in_ready=0 same cycle; s/ovf/cout/zero stable until accepted.
- Simultaneous output accept and input accept in same cycle is allowed (full throughput).
- out_valid=0 → in_ready=1 regardless of out_ready.
- Output registers are the only drivers of result ports; no combinational path from a/b to outputs. Only combinational input→output path: out_ready→in_ready.

## Structure
- Shared package alu_pkg: default N/BLK constants, function for L, struct for a stage record (operand slices, partial sum, carry, valid).
- Sub-module cla_block: combinational BLK-bit CLA built from 4-bit lookahead groups, outputs sum slice, group carry-out, carry into slice MSB (for ovf at last stage).
- Top instantiates L cla_block instances plus stage/skew registers.

## Test plan
- Reset: assert rst with 3 ops in flight → out_valid=0, s=0 immediately; after release in_ready=1, no stale result ever emitted.
- Add: a=32, b=61, sub=0, cin=0 → after 4 cycles s=93, ovf=0, cout=0, zero=0.
- Signed overflow: a=0x7FFFFFFF, b=1 → s=0x80000000, ovf=1, cout=0; a=0x80000000, b=0x80000000 → s=0, ovf=1, cout=1, zero=1.
- Subtract: a=5, b=100, sub=1, cin=0 → s=0xFFFFFFA1 (−95), ovf=0, cout=0; same with cin=1 → s=0xFFFFFFA0.
- Carry chain across all slices: a=0xFFFFFFFF, b=122, cin=0 → s=121, cout=1, ovf=0; cin=1 → s=122.
- Backpressure: 8 back-to-back random ops, out_ready low for cycles 5–7 → in_ready low those cycles, outputs held stable, all 8 results match reference model in order, no loss or duplication; repeat with N=16, BLK=4 (L=4).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions.
//   ALU_N / ALU_BLK : default operand width and bits resolved per pipeline stage
//   ALU_GRP         : width of one carry-lookahead group inside a slice
//   stage_ctl_t     : per-stage control record (valid bit, carry into the slice)
//   alu_stages()    : pipeline depth for a given width / slice size
package alu_pkg;

    localparam int unsigned ALU_N   = 32;
    localparam int unsigned ALU_BLK = 8;
    localparam int unsigned ALU_GRP = 4;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int unsigned alu_stages(input int unsigned n, input int unsigned blk);
        return n / blk;
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLK-bit carry-lookahead adder slice built from 4-bit groups.
//   a_i, b_i : operand slices (b_i already conditioned for subtraction)
//   cin_i    : carry into the slice LSB
//   s_o      : sum slice
//   cout_o   : carry out of the slice MSB
//   cmsb_o   : carry into the slice MSB (signed overflow detection)
module cla_block
    import alu_pkg::*;
#(
    parameter int unsigned BLK = ALU_BLK
) (
    input  logic [BLK-1:0] a_i,
    input  logic [BLK-1:0] b_i,
    input  logic           cin_i,
    output logic [BLK-1:0] s_o,
    output logic           cout_o,
    output logic           cmsb_o
);

    localparam int unsigned NG = BLK / ALU_GRP;

    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [NG-1:0]  gg;
    logic [NG-1:0]  pg;
    logic [NG:0]    cg;
    logic [BLK:0]   c;

    always_comb begin
        p  = a_i ^ b_i;
        g  = a_i & b_i;
        gg = '0;
        pg = '0;
        cg = '0;
        c  = '0;
        cg[0] = cin_i;
        for (int unsigned j = 0; j < NG; j++) begin
            // Group generate/propagate, then carries inside the group in
            // two-level form from the group carry-in.
            gg[j] = g[j*4+3]
                  | (p[j*4+3] & g[j*4+2])
                  | (p[j*4+3] & p[j*4+2] & g[j*4+1])
                  | (p[j*4+3] & p[j*4+2] & p[j*4+1] & g[j*4]);
            pg[j] = &p[j*4 +: 4];
            c[j*4]   = cg[j];
            c[j*4+1] = g[j*4] | (p[j*4] & cg[j]);
            c[j*4+2] = g[j*4+1] | (p[j*4+1] & g[j*4])
                     | (p[j*4+1] & p[j*4] & cg[j]);
            c[j*4+3] = g[j*4+2] | (p[j*4+2] & g[j*4+1])
                     | (p[j*4+2] & p[j*4+1] & g[j*4])
                     | (p[j*4+2] & p[j*4+1] & p[j*4] & cg[j]);
            cg[j+1]  = gg[j] | (pg[j] & cg[j]);
        end
        c[BLK] = cg[NG];
        s_o    = p ^ c[BLK-1:0];
        cout_o = c[BLK];
        cmsb_o = c[BLK-1];
    end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one BLK-bit slice per stage.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready = global advance)
//   a, b, sub, cin      : operands; sub=1 computes a-b with cin as borrow-in
//   out_valid/out_ready : result handshake
//   s, ovf, cout, zero  : registered result and flags
module cla_addsub_pipe
    import alu_pkg::*;
#(
    parameter int unsigned N   = ALU_N,
    parameter int unsigned BLK = ALU_BLK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         ovf,
    output logic         cout,
    output logic         zero
);

    localparam int unsigned L = alu_stages(N, BLK);

    if (N == 0 || BLK == 0 || (N % BLK) != 0 || (BLK % ALU_GRP) != 0) begin : g_param_check
        $error("cla_addsub_pipe: N must be a multiple of BLK and BLK a multiple of 4");
    end

    // Full-width operand and sum fields per stage; slices already consumed or
    // not yet produced are simply never read and drop out in synthesis.
    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] s;
        stage_ctl_t   ctl;
    } stage_t;

    stage_t         st_q [L];
    stage_t         st_d [L];
    logic [BLK-1:0] blk_s  [L];
    logic           blk_co [L];
    logic           blk_cm [L];

    logic           adv;
    logic [N-1:0]   fin_s;
    logic           vld_q;
    logic [N-1:0]   s_q;
    logic           ovf_q;
    logic           cout_q;
    logic           zero_q;

    assign adv      = !vld_q || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < L; k++) begin : g_slice
        cla_block #(.BLK(BLK)) u_blk (
            .a_i    (st_q[k].a[k*BLK +: BLK]),
            .b_i    (st_q[k].b[k*BLK +: BLK]),
            .cin_i  (st_q[k].ctl.carry),
            .s_o    (blk_s[k]),
            .cout_o (blk_co[k]),
            .cmsb_o (blk_cm[k])
        );
    end

    always_comb begin
        // Subtraction folded in as a + ~b + ~borrow.
        st_d[0].a         = a;
        st_d[0].b         = sub ? ~b : b;
        st_d[0].s         = '0;
        st_d[0].ctl.carry = sub ^ cin;
        st_d[0].ctl.valid = in_valid;
        for (int unsigned k = 1; k < L; k++) begin
            st_d[k]                       = st_q[k-1];
            st_d[k].s[(k-1)*BLK +: BLK]   = blk_s[k-1];
            st_d[k].ctl.carry             = blk_co[k-1];
        end
        fin_s                     = st_q[L-1].s;
        fin_s[(L-1)*BLK +: BLK]   = blk_s[L-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < L; k++) begin
                st_q[k] <= '0;
            end
            vld_q  <= 1'b0;
            s_q    <= '0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < L; k++) begin
                st_q[k] <= st_d[k];
            end
            vld_q  <= st_q[L-1].ctl.valid;
            s_q    <= fin_s;
            ovf_q  <= blk_cm[L-1] ^ blk_co[L-1];
            cout_q <= blk_co[L-1];
            zero_q <= (fin_s == '0);
        end
    end

    assign out_valid = vld_q;
    assign s         = s_q;
    assign ovf       = ovf_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        sub;
    logic        cin;

    logic        ir32, ov32, ovf32, co32, z32;
    logic [31:0] s32;
    logic        ir16, ov16, ovf16, co16, z16;
    logic [15:0] s16;

    int unsigned checks = 0;
    int unsigned passes = 0;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.N(32), .BLK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
        .a(a_in), .b(b_in), .sub(sub), .cin(cin),
        .out_valid(ov32), .out_ready(out_ready),
        .s(s32), .ovf(ovf32), .cout(co32), .zero(z32)
    );

    cla_addsub_pipe #(.N(16), .BLK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .a(a_in[15:0]), .b(b_in[15:0]), .sub(sub), .cin(cin),
        .out_valid(ov16), .out_ready(out_ready),
        .s(s16), .ovf(ovf16), .cout(co16), .zero(z16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, cout, s} for a w-bit add/sub, ovf from operand/result signs.
    function automatic logic [65:0] model(input logic [63:0] av, input logic [63:0] bv,
                                          input logic sv, input logic cv, input int unsigned w);
        logic [63:0] mask, ae, be, sres;
        logic [64:0] full;
        logic        co, ov;
        mask = (64'd1 << w) - 64'd1;
        ae   = av & mask;
        be   = (sv ? ~bv : bv) & mask;
        full = {1'b0, ae} + {1'b0, be} + {64'd0, sv ^ cv};
        sres = full[63:0] & mask;
        co   = full[w];
        ov   = (ae[w-1] == be[w-1]) && (sres[w-1] != ae[w-1]);
        return {ov, co, sres};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic cv, input logic [31:0] es,
                          input logic eovf, input logic ecout, input logic ezero);
        int unsigned lat;
        a_in = av; b_in = bv; sub = sv; cin = cv; in_valid = 1'b1;
        #1;
        chk({tag, ".in_ready"}, {63'd0, ir32}, 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!ov32 && lat < 12) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'd4);
        chk({tag, ".s"},    {32'd0, s32},   {32'd0, es});
        chk({tag, ".ovf"},  {63'd0, ovf32}, {63'd0, eovf});
        chk({tag, ".cout"}, {63'd0, co32},  {63'd0, ecout});
        chk({tag, ".zero"}, {63'd0, z32},   {63'd0, ezero});
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] opa [8];
        logic [31:0] opb [8];
        logic        ops [8];
        logic        opc [8];
        logic [65:0] e32 [8];
        logic [65:0] e16 [8];
        int unsigned ii, o32, o16, extra, stale;
        logic        acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; sub = 1'b0; cin = 1'b0;

        // Reset state
        #12;
        chk("rst.out_valid", {63'd0, ov32}, 64'd0);
        chk("rst.s",         {32'd0, s32},  64'd0);
        chk("rst.ovf_cout_zero", {61'd0, ovf32, co32, z32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.in_ready", {63'd0, ir32}, 64'd1);
        tick();

        // Directed single operations (hand-computed)
        run_op("add",     32'd32,        32'd61,        1'b0, 1'b0, 32'd93,        1'b0, 1'b0, 1'b0);
        run_op("ovf_pos", 32'h7FFFFFFF,  32'd1,         1'b0, 1'b0, 32'h80000000,  1'b1, 1'b0, 1'b0);
        run_op("ovf_neg", 32'h80000000,  32'h80000000,  1'b0, 1'b0, 32'h00000000,  1'b1, 1'b1, 1'b1);
        run_op("sub",     32'd5,         32'd100,       1'b1, 1'b0, 32'hFFFFFFA1,  1'b0, 1'b0, 1'b0);
        run_op("sub_brw", 32'd5,         32'd100,       1'b1, 1'b1, 32'hFFFFFFA0,  1'b0, 1'b0, 1'b0);
        run_op("sub_pos", 32'd100,       32'd5,         1'b1, 1'b0, 32'h0000005F,  1'b0, 1'b1, 1'b0);
        run_op("sub_zero",32'd0,         32'd0,         1'b1, 1'b0, 32'h00000000,  1'b0, 1'b1, 1'b1);
        run_op("chain",   32'hFFFFFFFF,  32'd122,       1'b0, 1'b0, 32'd121,       1'b0, 1'b1, 1'b0);
        run_op("chain_c", 32'hFFFFFFFF,  32'd122,       1'b0, 1'b1, 32'd122,       1'b0, 1'b1, 1'b0);

        // Reset with three operations in flight
        sub = 1'b0; cin = 1'b0; b_in = 32'd1; in_valid = 1'b1;
        a_in = 32'd1000; tick();
        a_in = 32'd2000; tick();
        a_in = 32'd3000; tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("midrst.pre_valid", {63'd0, ov32}, 64'd1);
        chk("midrst.pre_s",     {32'd0, s32},  64'd1001);
        out_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", {63'd0, ov32}, 64'd0);
        chk("midrst.s",         {32'd0, s32},  64'd0);
        chk("midrst.in_ready",  {63'd0, ir32}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ov32 || ov16) stale++;
        end
        chk("midrst.no_stale", 64'(stale), 64'd0);

        // Back-to-back stream with output stall in cycles 5..7, both geometries
        for (int i = 0; i < 8; i++) begin
            opa[i] = $urandom();
            opb[i] = $urandom();
            ops[i] = 1'($urandom_range(0, 1));
            opc[i] = 1'($urandom_range(0, 1));
            e32[i] = model({32'd0, opa[i]}, {32'd0, opb[i]}, ops[i], opc[i], 32);
            e16[i] = model({32'd0, opa[i]}, {32'd0, opb[i]}, ops[i], opc[i], 16);
        end
        ii = 0; o32 = 0; o16 = 0; extra = 0;
        for (int cyc = 0; cyc < 40 && (o32 < 8 || o16 < 8); cyc++) begin
            in_valid  = (ii < 8);
            a_in      = (ii < 8) ? opa[ii] : 32'd0;
            b_in      = (ii < 8) ? opb[ii] : 32'd0;
            sub       = (ii < 8) ? ops[ii] : 1'b0;
            cin       = (ii < 8) ? opc[ii] : 1'b0;
            out_ready = !(cyc >= 5 && cyc <= 7);
            #1;
            if (cyc < 8) begin
                chk($sformatf("bp.in_ready32[%0d]", cyc), {63'd0, ir32}, {63'd0, !(cyc >= 5)});
                chk($sformatf("bp.in_ready16[%0d]", cyc), {63'd0, ir16}, {63'd0, !(cyc >= 5)});
            end
            if (cyc >= 5 && cyc <= 7) begin
                chk($sformatf("bp.hold_valid[%0d]", cyc), {63'd0, ov32}, 64'd1);
                chk($sformatf("bp.hold_s32[%0d]", cyc),   {32'd0, s32},  e32[0][63:0]);
                chk($sformatf("bp.hold_s16[%0d]", cyc),   {48'd0, s16},  e16[0][63:0]);
            end
            if (ov32 && out_ready) begin
                if (o32 < 8) begin
                    chk($sformatf("bp.s32[%0d]", o32),    {32'd0, s32}, e32[o32][63:0]);
                    chk($sformatf("bp.flags32[%0d]", o32), {62'd0, ovf32, co32}, {62'd0, e32[o32][65:64]});
                    chk($sformatf("bp.zero32[%0d]", o32), {63'd0, z32}, {63'd0, e32[o32][31:0] == 32'd0});
                end else extra++;
                o32++;
            end
            if (ov16 && out_ready) begin
                if (o16 < 8) begin
                    chk($sformatf("bp.s16[%0d]", o16),    {48'd0, s16}, e16[o16][63:0]);
                    chk($sformatf("bp.flags16[%0d]", o16), {62'd0, ovf16, co16}, {62'd0, e16[o16][65:64]});
                end else extra++;
                o16++;
            end
            acc = in_valid && ir32;
            tick();
            if (acc) ii++;
        end
        chk("bp.count32", 64'(o32), 64'd8);
        chk("bp.count16", 64'(o16), 64'd8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov32 || ov16) extra++;
        end
        chk("bp.no_duplicate", 64'(extra), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
